// File: rtl/spi_frame_rx.sv
// Oversampling SPI (mode 0) slave front end: decodes write/read frames into register strobes.
// Define SPI_GLITCH_FILTER_EN to add a third sync stage and a 2-sample agreement filter on sclk/cs.
module spi_frame_rx #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  WR_CMD = 8'hF0,
  parameter logic [7:0]  RD_CMD = 8'h0F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd_req,
  input  logic [7:0]        reg_rdata,
  output logic              frame_err
);

`ifdef SPI_GLITCH_FILTER_EN
  localparam int unsigned PipeW = 4;
`else
  localparam int unsigned PipeW = 3;
`endif

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddrW, StWdata, StAddrR, StRdata, StDiscard
  } state_e;

  logic [PipeW-1:0] sclk_pipe_q, cs_pipe_q;
  logic [1:0]       mosi_pipe_q;
  logic             sclk_rise, sclk_fall, cs_rise, cs_fall;

  // cs chain resets high so a cs already asserted across reset is not seen as a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_pipe_q <= '0;
      cs_pipe_q   <= '1;
      mosi_pipe_q <= '0;
    end else begin
      sclk_pipe_q <= {sclk_pipe_q[PipeW-2:0], spi_sclk};
      cs_pipe_q   <= {cs_pipe_q[PipeW-2:0], spi_cs};
      mosi_pipe_q <= {mosi_pipe_q[0], spi_mosi};
    end
  end

`ifdef SPI_GLITCH_FILTER_EN
  logic sclk_filt_q, cs_filt_q;
  logic sclk_acc, cs_acc;

  always_comb begin
    sclk_acc  = (sclk_pipe_q[2] == sclk_pipe_q[3]) && (sclk_pipe_q[2] != sclk_filt_q);
    cs_acc    = (cs_pipe_q[2] == cs_pipe_q[3]) && (cs_pipe_q[2] != cs_filt_q);
    sclk_rise = sclk_acc & sclk_pipe_q[2];
    sclk_fall = sclk_acc & ~sclk_pipe_q[2];
    cs_rise   = cs_acc & cs_pipe_q[2];
    cs_fall   = cs_acc & ~cs_pipe_q[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_filt_q <= 1'b0;
      cs_filt_q   <= 1'b1;
    end else begin
      if (sclk_acc) sclk_filt_q <= sclk_pipe_q[2];
      if (cs_acc)   cs_filt_q   <= cs_pipe_q[2];
    end
  end
`else
  always_comb begin
    sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
    sclk_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
    cs_rise   = cs_pipe_q[1] & ~cs_pipe_q[2];
    cs_fall   = ~cs_pipe_q[1] & cs_pipe_q[2];
  end
`endif

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q, tx_q;
  logic       rd_cap_q;
  logic       byte_done;
  logic [7:0] byte_val;

  always_comb begin
    byte_val  = {shift_q[6:0], mosi_pipe_q[1]};
    byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      rd_cap_q   <= 1'b0;
      spi_miso   <= 1'b0;
      reg_wr_en  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_rd_req <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      reg_wr_en  <= 1'b0;
      reg_rd_req <= 1'b0;
      frame_err  <= 1'b0;
      rd_cap_q   <= reg_rd_req;
      if (rd_cap_q) tx_q <= reg_rdata;
      if (reg_wr_en) reg_addr <= reg_addr + 1'b1;

      if (cs_fall) begin
        // cs loss wins over any byte completing in the same cycle.
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        spi_miso  <= 1'b0;
      end else if (state_q == StIdle) begin
        spi_miso <= 1'b0;
        if (cs_rise) begin
          state_q   <= StCmd;
          bit_cnt_q <= '0;
        end
      end else begin
        if (sclk_rise) begin
          shift_q   <= byte_val;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        case (state_q)
          StCmd: if (byte_done) begin
            if (byte_val == WR_CMD) begin
              state_q <= StAddrW;
            end else if (byte_val == RD_CMD) begin
              state_q <= StAddrR;
            end else begin
              state_q   <= StDiscard;
              frame_err <= 1'b1;
            end
          end
          StAddrW: if (byte_done) begin
            reg_addr <= byte_val[ADDR_W-1:0];
            state_q  <= StWdata;
          end
          StWdata: if (byte_done) begin
            reg_wr_en <= 1'b1;
            reg_wdata <= byte_val;
          end
          StAddrR: if (byte_done) begin
            reg_addr   <= byte_val[ADDR_W-1:0];
            reg_rd_req <= 1'b1;
            state_q    <= StRdata;
          end
          StRdata: begin
            if (sclk_fall) begin
              spi_miso <= tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
            end
            if (byte_done) begin
              reg_addr   <= reg_addr + 1'b1;
              reg_rd_req <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: table-driven frames with a strobe scoreboard.
module tb_spi_frame_rx;

  localparam int HALF = 8;

  logic       clk, rst_n;
  logic       spi_sclk, spi_cs, spi_mosi, spi_miso;
  logic       reg_wr_en, reg_rd_req, frame_err;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  int wr_seen = 0;

  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];

  spi_frame_rx #(.ADDR_W(8), .WR_CMD(8'hF0), .RD_CMD(8'h0F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rd_req (reg_rd_req),
    .reg_rdata  (reg_rdata),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd_model(input logic [7:0] a);
    if (a == 8'h03) return 8'h3C;
    if (a == 8'h04) return 8'hC3;
    return a ^ 8'h5A;
  endfunction

  assign reg_rdata = rd_model(reg_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: every write/read strobe must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr_en) begin
        wr_seen++;
        if (exp_wr_q.size() == 0) check("unexpected_wr", {16'h0, reg_addr, reg_wdata}, 32'hDEAD);
        else check("wr_addr_data", {16'h0, reg_addr, reg_wdata}, {16'h0, exp_wr_q.pop_front()});
      end
      if (reg_rd_req) begin
        if (exp_rd_q.size() == 0) check("unexpected_rd", {24'h0, reg_addr}, 32'hDEAD);
        else check("rd_addr", {24'h0, reg_addr}, {24'h0, exp_rd_q.pop_front()});
      end
      if (frame_err) err_seen++;
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input int glitch_at,
                          output logic [7:0] rx);
    logic [7:0] sh;
    sh = tx;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = sh[7];
      sh = {sh[6:0], 1'b0};
      if (i == glitch_at) begin
        repeat (3) @(negedge clk);
        spi_sclk = 1'b1;
        @(negedge clk);
        spi_sclk = 1'b0;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      spi_sclk = 1'b1;
      rx = {rx[6:0], spi_miso};
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  // Sends n full bytes plus tail_bits of byte n; expectations come from a frame-level model.
  task automatic run_frame(input string name, input logic [47:0] bytes, input int n,
                           input int tail_bits, input int exp_err, input int exp_nwr,
                           input int glitch_byte, input int glitch_bit);
    logic [7:0] b0, a, bj, rx, exp_rx;
    b0 = bytes[47:40];
    a  = bytes[39:32];
    if (n >= 2 && b0 == 8'hF0)
      for (int k = 0; k < n - 2; k++) begin
        bj = bytes[31 - 8 * k -: 8];
        exp_wr_q.push_back({a + 8'(k), bj});
      end
    if (n >= 2 && b0 == 8'h0F)
      for (int k = 0; k < n - 1; k++) exp_rd_q.push_back(a + 8'(k));
    err_seen = 0;
    wr_seen  = 0;
    spi_cs = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int j = 0; j <= n; j++) begin
      bj = bytes[47 - 8 * j -: 8];
      if (j < n) begin
        spi_bits(bj, 8, (j == glitch_byte) ? glitch_bit : -1, rx);
        exp_rx = (b0 == 8'h0F && j >= 2) ? rd_model(a + 8'(j - 2)) : 8'h00;
        check({name, "_miso"}, {24'h0, rx}, {24'h0, exp_rx});
      end else if (tail_bits > 0) begin
        spi_bits(bj, tail_bits, -1, rx);
      end
    end
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b0;
    repeat (12) @(negedge clk);
    check({name, "_err"}, err_seen, exp_err);
    check({name, "_nwr"}, wr_seen, exp_nwr);
    check({name, "_wrq_left"}, exp_wr_q.size(), 0);
    check({name, "_rdq_left"}, exp_rd_q.size(), 0);
  endtask

  typedef struct packed {
    logic [47:0] bytes;
    logic [3:0]  n;
    logic [3:0]  exp_nwr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] rx;
    vecs[0] = '{bytes: 48'hF0_05_A5_00_00_00, n: 4'd3, exp_nwr: 4'd1, exp_err: 1'b0};
    vecs[1] = '{bytes: 48'hF0_FE_11_22_33_00, n: 4'd5, exp_nwr: 4'd3, exp_err: 1'b0};
    vecs[2] = '{bytes: 48'h0F_03_00_00_00_00, n: 4'd4, exp_nwr: 4'd0, exp_err: 1'b0};
    vecs[3] = '{bytes: 48'h55_01_02_00_00_00, n: 4'd3, exp_nwr: 4'd0, exp_err: 1'b1};
    vecs[4] = '{bytes: 48'hF0_10_5A_00_00_00, n: 4'd3, exp_nwr: 4'd1, exp_err: 1'b0};
    vecs[5] = '{bytes: 48'h0F_FF_00_00_00_00, n: 4'd4, exp_nwr: 4'd0, exp_err: 1'b0};

    rst_n = 1'b0; spi_sclk = 1'b0; spi_cs = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_rd_req", reg_rd_req, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_miso", spi_miso, 0);
    check("rst_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].bytes, int'(vecs[v].n), 0,
                int'(vecs[v].exp_err), int'(vecs[v].exp_nwr), -1, -1);

    // Abort mid data byte: the partial byte must not produce a write.
    run_frame("abort", 48'hF0_07_B0_00_00_00, 2, 4, 0, 0, -1, -1);
    run_frame("post_abort", 48'hF0_07_99_00_00_00, 3, 0, 0, 1, -1, -1);

    // Reset during a read while MISO is driving a 1.
    exp_rd_q.push_back(8'h03);
    spi_cs = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h0F, 8, -1, rx);
    spi_bits(8'h03, 8, -1, rx);
    spi_bits(8'h00, 3, -1, rx);
    repeat (5) @(negedge clk);
    check("pre_rst_miso", spi_miso, 1);
    check("pre_rst_addr", reg_addr, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_miso", spi_miso, 0);
    check("midrst_addr", reg_addr, 0);
    check("midrst_rd_req", reg_rd_req, 0);
    check("midrst_wr_en", reg_wr_en, 0);
    check("midrst_err", frame_err, 0);
    spi_cs = 1'b0; spi_sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_rdq_left", exp_rd_q.size(), 0);
    run_frame("post_rst", vecs[0].bytes, 3, 0, 0, 1, -1, -1);

`ifdef SPI_GLITCH_FILTER_EN
    run_frame("glitch", 48'hF0_20_6C_00_00_00, 3, 0, 0, 1, 2, 3);
`endif

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- SPI slave front end for the IO expander register file; runs entirely in the internal oscillator domain.
- Oversamples the SPI pins, decodes byte-framed write/read transactions and issues single-cycle register write strobes and read requests to the register bank.
- Shifts read data back out on MISO.
- Sits directly upstream of the register/PWM/bidir logic and replaces direct SPI-clocked register access.

Parameters:
- ADDR_W, 8, register address width; the address byte is truncated to its low ADDR_W bits.
- WR_CMD, 8'hF0, command byte selecting a write frame.
- RD_CMD, 8'h0F, command byte selecting a read frame.

Ports:
- clk  input  1  system clock (internal oscillator)
- rst_n  input  1  asynchronous active-low reset
- spi_sclk  input  1  SPI clock, mode 0, asynchronous to clk
- spi_cs  input  1  frame enable, active high, asynchronous
- spi_mosi  input  1  serial data in, MSB first
- spi_miso  output  1  serial data out, MSB first
- reg_wr_en  output  1  one-cycle register write strobe
- reg_addr  output  ADDR_W  address for write or read
- reg_wdata  output  8  write data, valid with reg_wr_en
- reg_rd_req  output  1  one-cycle read request
- reg_rdata  input  8  read data, sampled exactly 1 clk after reg_rd_req
- frame_err  output  1  one-cycle pulse on an unknown command byte

Behaviour:
- Reset:
  - all outputs are 0 and state is IDLE.
  - Reset is asynchronous assert and synchronous release in behaviour; no further sync is done inside the block.
- Input synchronisation:
  - spi_sclk, spi_cs and spi_mosi each pass through a 2-flop synchroniser.
  - A rising or falling sclk edge is detected from the synchronised value versus its previous value.
  - spi_mosi is sampled on the cycle the rising edge is detected.
- Timing requirement: sclk high and low times are each at least 4 clk cycles (6 with the optional feature). Faster sclk gives undefined results; the block must not hang.
- Bit counting:
  - A 3-bit counter counts rising edges.
  - The byte completes on the 8th edge; the counter wraps to 0.
  - Shift register: shift left, new bit in at the LSB.
- States and transitions:
  - IDLE -> CMD when synchronised cs rises.
  - CMD, byte complete:
    - byte == WR_CMD -> ADDR_W_ (write path).
    - byte == RD_CMD -> ADDR_R (read path).
    - any other byte -> DISCARD, with frame_err pulsed for 1 cycle.
  - ADDR_W_, byte complete: latch the address -> WDATA.
  - WDATA, byte complete:
    - the next cycle drives reg_wr_en=1 with reg_addr and reg_wdata.
    - the following cycle reg_addr increments, wrapping mod 2^ADDR_W.
    - stays in WDATA, so multi-byte writes auto-increment.
  - ADDR_R, byte complete: latch the address, pulse reg_rd_req the next cycle, capture reg_rdata into the tx shift register 1 cycle later -> RDATA.
  - RDATA:
    - spi_miso presents the tx MSB from the first falling sclk edge after the address byte.
    - the tx register shifts on each subsequent falling edge.
    - after the 8th rising edge of a read byte: reg_addr increments, reg_rd_req pulses and the next byte is reloaded before the next falling edge.
  - DISCARD: ignore all bits until cs falls.
- cs handling:
  - Synchronised cs falling in any state returns to IDLE next cycle, clears the bit counter and drives spi_miso to 0.
  - A partial byte is dropped; no write is issued for it.
  - A cs rise while already active is impossible by construction and needs no handling.
- spi_miso is 0 outside RDATA.
- Simultaneous events:
  - A byte completion and a cs fall detected in the same cycle: cs wins and no strobe is issued.
  - A read auto-increment coinciding with address wrap: 2^ADDR_W-1 -> 0.
- Reset mid-frame aborts immediately; the next frame must begin with a fresh cs rise.

Optional Feature:
- Macro SPI_GLITCH_FILTER_EN.
- When defined:
  - a 3rd synchroniser stage is added on sclk and cs.
  - an edge is accepted only when the last 2 synchronised samples agree and differ from the filtered level.
  - single-cycle glitches are ignored.
  - detection latency is +2 clk.
- When undefined: plain 2-flop synchroniser with no filtering.

Test Plan:
- Write: frame F0, 05, A5 -> exactly one reg_wr_en with reg_addr=5 and reg_wdata=A5; frame_err stays 0.
- Burst write: frame F0, FE, 11, 22, 33 with ADDR_W=8 -> writes FE=11, FF=22, 00=33 (wrap).
- Read: frame 0F, 03 then 2 dummy bytes, with reg_rdata returning 8'h3C for addr 3 and 8'hC3 for addr 4 -> MISO bytes 3C then C3; reg_rd_req pulses at addr 3 and addr 4.
- Abort: F0, 07, then 4 data bits and cs low -> no reg_wr_en; the next clean write frame works.
- Bad command: 55, 01, 02 -> one frame_err pulse, no write or read strobes, MISO held 0.
- rst_n asserted mid-read -> all outputs 0 asynchronously; with SPI_GLITCH_FILTER_EN, a 1-cycle sclk glitch during a write produces no extra bit.
